// File: rtl/test_sequencer_pkg.sv
// Shared types, the random-address polynomial and mode helpers for test_sequencer.
package test_sequencer_pkg;

    typedef enum logic [1:0] {
        READ_ONLY       = 2'd0,
        WRITE_ONLY      = 2'd1,
        WRITE_AND_CHECK = 2'd2,
        TEST_RSVD       = 2'd3
    } test_mode_t;

    typedef enum logic [1:0] {
        FIX_ADDR  = 2'd0,
        RND_ADDR  = 2'd1,
        RUN_ADDR  = 2'd2,
        ADDR_RSVD = 2'd3
    } addr_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Right-shifting Galois taps for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_POLY : 32'h0000_0000);
    endfunction

    function automatic test_mode_t norm_test_mode(input logic [1:0] raw);
        test_mode_t m;
        case (raw)
            2'd1:    m = WRITE_ONLY;
            2'd2:    m = WRITE_AND_CHECK;
            default: m = READ_ONLY;
        endcase
        return m;
    endfunction

    function automatic addr_mode_t norm_addr_mode(input logic [1:0] raw);
        addr_mode_t m;
        case (raw)
            2'd1:    m = RND_ADDR;
            2'd2:    m = RUN_ADDR;
            default: m = FIX_ADDR;
        endcase
        return m;
    endfunction

    // Transfer type that opens an address unit: 1 = read, 0 = write.
    function automatic logic first_type(input test_mode_t m);
        return (m == READ_ONLY) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/test_sequencer_addr_gen.sv
// Address generator: fixed, running or LFSR-random address register with load/advance.
module test_sequencer_addr_gen
    import test_sequencer_pkg::*;
#(
    parameter int          ADDR_W    = 31,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  addr_mode_t        mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] incr,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] SEED_ADDR = LFSR_SEED[ADDR_W-1:0];

    addr_mode_t        mode_r;
    logic [ADDR_W-1:0] incr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       lfsr_r;
    logic [31:0]       lfsr_nxt_s;

    assign lfsr_nxt_s = lfsr_step(lfsr_r);
    assign addr       = addr_r;

    // Address and LFSR state; the first random address is the seed itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r <= FIX_ADDR;
            incr_r <= {ADDR_W{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
            lfsr_r <= LFSR_SEED;
        end else if (load) begin
            mode_r <= mode;
            incr_r <= incr;
            lfsr_r <= LFSR_SEED;
            addr_r <= (mode == RND_ADDR) ? SEED_ADDR : base;
        end else if (advance) begin
            case (mode_r)
                RND_ADDR: begin
                    lfsr_r <= lfsr_nxt_s;
                    addr_r <= lfsr_nxt_s[ADDR_W-1:0];
                end
                RUN_ADDR: addr_r <= addr_r + incr_r;
                default:  addr_r <= addr_r;
            endcase
        end else begin
            addr_r <= addr_r;
        end
    end

endmodule

// File: rtl/test_sequencer.sv
// Test-level controller driving the transmitter request interface.
// Optional macro TRANS_DELAY_EN adds delay_i: idle cycles inserted after every accept.
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int          ADDR_W    = 31,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic              clk_i,
    input  logic              rst_i,
`ifdef TRANS_DELAY_EN
    input  logic [7:0]        delay_i,
`endif
    input  logic              start_i,
    input  logic [1:0]        test_mode_i,
    input  logic [1:0]        addr_mode_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] addr_incr_i,
    input  logic [CNT_W-1:0]  trans_count_i,
    input  logic              trans_ready_i,
    input  logic              trans_busy_i,
    input  logic              cmp_error_i,
    output logic              trans_valid_o,
    output logic [ADDR_W-1:0] trans_addr_o,
    output logic              trans_type_o,
    output logic              test_busy_o,
    output logic              test_done_o,
    output logic              test_result_o,
    output logic [CNT_W-1:0]  trans_done_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_t       state_r, state_nxt_s;
    test_mode_t       mode_r, mode_n;
    logic [CNT_W-1:0] units_r, units_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic             phase_r, phase_n;
    logic             valid_r, valid_n;
    logic             type_r, type_n;
    logic             busy_r, busy_n;
    logic             done_r, done_n;
    logic             result_r, result_n;
    logic             load_s, adv_s;
    logic             accept_s, unit_done_s, last_unit_s;
`ifdef TRANS_DELAY_EN
    logic [7:0]       delay_r, delay_n;
    logic [7:0]       gap_r, gap_n;
`endif

    assign accept_s    = valid_r && trans_ready_i;
    assign unit_done_s = accept_s && ((mode_r != WRITE_AND_CHECK) || phase_r);
    assign last_unit_s = unit_done_s && (units_r == CNT_ONE);

    test_sequencer_addr_gen #(
        .ADDR_W    (ADDR_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_addr_gen (
        .clk     (clk_i),
        .rst     (rst_i),
        .load    (load_s),
        .advance (adv_s),
        .mode    (norm_addr_mode(addr_mode_i)),
        .base    (base_addr_i),
        .incr    (addr_incr_i),
        .addr    (trans_addr_o)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; an error in ISSUE abandons the remaining units.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_nxt_s = (trans_count_i == CNT_ZERO) ? DONE : ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (cmp_error_i || last_unit_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            DRAIN: begin
                if (!trans_busy_i) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and the per-test bookkeeping.
    always_comb begin
        mode_n   = mode_r;
        units_n  = units_r;
        cnt_n    = cnt_r;
        phase_n  = phase_r;
        valid_n  = valid_r;
        type_n   = type_r;
        result_n = result_r;
        load_s   = 1'b0;
        adv_s    = 1'b0;
        busy_n   = (state_nxt_s == ISSUE) || (state_nxt_s == DRAIN);
        done_n   = (state_r == DONE);
`ifdef TRANS_DELAY_EN
        delay_n  = delay_r;
        gap_n    = gap_r;
`endif
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    mode_n   = norm_test_mode(test_mode_i);
                    units_n  = trans_count_i;
                    cnt_n    = CNT_ZERO;
                    phase_n  = 1'b0;
                    result_n = 1'b0;
                    load_s   = 1'b1;
                    valid_n  = (trans_count_i != CNT_ZERO);
                    type_n   = first_type(norm_test_mode(test_mode_i));
`ifdef TRANS_DELAY_EN
                    delay_n  = delay_i;
                    gap_n    = 8'd0;
`endif
                end else begin
                    valid_n = 1'b0;
                end
            end
            ISSUE: begin
                if (accept_s) begin
                    cnt_n = cnt_r + CNT_ONE;
                end else begin
                    cnt_n = cnt_r;
                end
                // Address is held across the write/read pair and moves only per unit.
                if (unit_done_s) begin
                    units_n = units_r - CNT_ONE;
                    phase_n = 1'b0;
                    type_n  = first_type(mode_r);
                    adv_s   = !last_unit_s;
                end else if (accept_s) begin
                    phase_n = 1'b1;
                    type_n  = 1'b1;
                end else begin
                    phase_n = phase_r;
                end
                if (cmp_error_i) begin
                    result_n = 1'b1;
                end else begin
                    result_n = result_r;
                end
                if (cmp_error_i || last_unit_s) begin
                    valid_n = 1'b0;
                end
`ifdef TRANS_DELAY_EN
                else if (accept_s && (delay_r != 8'd0)) begin
                    valid_n = 1'b0;
                    gap_n   = delay_r;
                end else if (gap_r != 8'd0) begin
                    gap_n   = gap_r - 8'd1;
                    valid_n = (gap_r == 8'd1);
                end
`endif
                else begin
                    valid_n = 1'b1;
                end
            end
            DRAIN: begin
                valid_n = 1'b0;
                if (cmp_error_i) begin
                    result_n = 1'b1;
                end else begin
                    result_n = result_r;
                end
            end
            DONE: begin
                valid_n = 1'b0;
            end
            default: begin
                valid_n  = 1'b0;
                result_n = 1'b0;
            end
        endcase
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_r   <= READ_ONLY;
            units_r  <= CNT_ZERO;
            cnt_r    <= CNT_ZERO;
            phase_r  <= 1'b0;
            valid_r  <= 1'b0;
            type_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= 1'b0;
`ifdef TRANS_DELAY_EN
            delay_r  <= 8'd0;
            gap_r    <= 8'd0;
`endif
        end else begin
            mode_r   <= mode_n;
            units_r  <= units_n;
            cnt_r    <= cnt_n;
            phase_r  <= phase_n;
            valid_r  <= valid_n;
            type_r   <= type_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
            result_r <= result_n;
`ifdef TRANS_DELAY_EN
            delay_r  <= delay_n;
            gap_r    <= gap_n;
`endif
        end
    end

    assign trans_valid_o    = valid_r;
    assign trans_type_o     = type_r;
    assign test_busy_o      = busy_r;
    assign test_done_o      = done_r;
    assign test_result_o    = result_r;
    assign trans_done_cnt_o = cnt_r;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed self-checking bench for test_sequencer (define TRANS_DELAY_EN to cover the gap feature).
module tb_test_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  test_mode = 2'd0;
    logic [1:0]  addr_mode = 2'd0;
    logic [30:0] base_addr = 31'd0;
    logic [30:0] addr_incr = 31'd0;
    logic [31:0] trans_count = 32'd0;
    logic        ready = 1'b0;
    logic        busy_in = 1'b0;
    logic        cmp_error = 1'b0;
`ifdef TRANS_DELAY_EN
    logic [7:0]  delay = 8'd0;
`endif
    logic        valid;
    logic [30:0] addr;
    logic        ttype;
    logic        test_busy;
    logic        test_done;
    logic        test_result;
    logic [31:0] done_cnt;

    int passed = 0;
    int total  = 0;

    test_sequencer #(
        .ADDR_W    (31),
        .CNT_W     (32),
        .LFSR_SEED (32'hACE1_2468)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
`ifdef TRANS_DELAY_EN
        .delay_i          (delay),
`endif
        .start_i          (start),
        .test_mode_i      (test_mode),
        .addr_mode_i      (addr_mode),
        .base_addr_i      (base_addr),
        .addr_incr_i      (addr_incr),
        .trans_count_i    (trans_count),
        .trans_ready_i    (ready),
        .trans_busy_i     (busy_in),
        .cmp_error_i      (cmp_error),
        .trans_valid_o    (valid),
        .trans_addr_o     (addr),
        .trans_type_o     (ttype),
        .test_busy_o      (test_busy),
        .test_done_o      (test_done),
        .test_result_o    (test_result),
        .trans_done_cnt_o (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic launch(input logic [1:0] tm, input logic [1:0] am, input logic [30:0] b,
                          input logic [30:0] inc, input logic [31:0] cnt);
        test_mode   = tm;
        addr_mode   = am;
        base_addr   = b;
        addr_incr   = inc;
        trans_count = cnt;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    logic [30:0] rnd_exp [5];
    logic        wac_type [4];
    int          idx;
    logic        rdy_now;

    initial begin
        rnd_exp[0] = 31'h2CE1_2468;
        rnd_exp[1] = 31'h5670_9234;
        rnd_exp[2] = 31'h2B38_491A;
        rnd_exp[3] = 31'h159C_248D;
        rnd_exp[4] = 31'h0AEE_1245;
        wac_type[0] = 1'b0; wac_type[1] = 1'b1; wac_type[2] = 1'b0; wac_type[3] = 1'b1;

        // Reset state
        @(negedge clk);
        tick(); tick();
        check("rst_valid", valid, 0);
        check("rst_busy", test_busy, 0);
        check("rst_done", test_done, 0);
        check("rst_cnt", done_cnt, 0);
        check("rst_addr", addr, 0);
        rst = 1'b0;
        tick();

        // WRITE_ONLY, RUN_ADDR 0x100 +4, count 3, drain held by busy for one cycle
        ready = 1'b1; busy_in = 1'b1;
        launch(2'd1, 2'd2, 31'h100, 31'd4, 32'd3);
        check("run_valid0", valid, 1);
        check("run_addr0", addr, 31'h100);
        check("run_type0", ttype, 0);
        check("run_busy", test_busy, 1);
        tick();
        check("run_addr1", addr, 31'h104);
        check("run_valid1", valid, 1);
        tick();
        check("run_addr2", addr, 31'h108);
        tick();
        check("run_valid_end", valid, 0);
        check("run_cnt", done_cnt, 3);
        tick();
        check("run_drain_busy", test_busy, 1);
        check("run_drain_nodone", test_done, 0);
        busy_in = 1'b0;
        tick();
        check("run_done_state_busy", test_busy, 0);
        tick();
        check("run_done", test_done, 1);
        check("run_result", test_result, 0);
        check("run_cnt_final", done_cnt, 3);
        tick();
        check("run_done_pulse", test_done, 0);

        // WRITE_AND_CHECK, FIX_ADDR 0x40, count 2
        launch(2'd2, 2'd0, 31'h40, 31'd8, 32'd2);
        for (int k = 0; k < 4; k++) begin
            check("wac_valid", valid, 1);
            check("wac_type", ttype, wac_type[k]);
            check("wac_addr", addr, 31'h40);
            tick();
        end
        check("wac_valid_end", valid, 0);
        tick(); tick();
        check("wac_done", test_done, 1);
        check("wac_cnt", done_cnt, 4);

        // RND_ADDR, count 5, ready once every three cycles
        ready = 1'b0;
        launch(2'd1, 2'd1, 31'h0, 31'h0, 32'd5);
        idx = 0;
        for (int k = 0; k < 40 && idx < 5; k++) begin
            rdy_now = (k % 3 == 2);
            ready   = rdy_now;
            check("rnd_valid", valid, 1);
            check("rnd_addr", addr, rnd_exp[idx]);
            check("rnd_type", ttype, 0);
            tick();
            if (rdy_now) idx++;
        end
        ready = 1'b0;
        check("rnd_accepts", idx, 5);
        check("rnd_valid_end", valid, 0);
        tick(); tick();
        check("rnd_done", test_done, 1);
        check("rnd_cnt", done_cnt, 5);

        // Compare error after the 2nd accept of 10
        ready = 1'b1; busy_in = 1'b1;
        launch(2'd2, 2'd0, 31'h10, 31'd0, 32'd10);
        tick(); tick();
        check("err_cnt_pre", done_cnt, 2);
        ready = 1'b0; cmp_error = 1'b1;
        tick();
        cmp_error = 1'b0;
        check("err_valid", valid, 0);
        check("err_result", test_result, 1);
        check("err_busy", test_busy, 1);
        tick();
        check("err_drain_busy", test_busy, 1);
        check("err_drain_nodone", test_done, 0);
        busy_in = 1'b0;
        tick(); tick();
        check("err_done", test_done, 1);
        check("err_result_done", test_result, 1);
        check("err_cnt", done_cnt, 2);

        // Zero count: done two cycles after start, result cleared
        ready = 1'b1;
        launch(2'd0, 2'd0, 31'h55, 31'd0, 32'd0);
        check("zero_valid", valid, 0);
        check("zero_busy", test_busy, 0);
        check("zero_done_early", test_done, 0);
        check("zero_result_clr", test_result, 0);
        tick();
        check("zero_done", test_done, 1);
        check("zero_result", test_result, 0);
        tick();

        // Reset mid-ISSUE
        launch(2'd1, 2'd0, 31'h20, 31'd0, 32'd5);
        tick();
        check("rstmid_cnt_pre", done_cnt, 1);
        rst = 1'b1;
        tick();
        check("rstmid_valid", valid, 0);
        check("rstmid_busy", test_busy, 0);
        check("rstmid_cnt", done_cnt, 0);
        check("rstmid_addr", addr, 0);
        rst = 1'b0; ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rstmid_nodone", test_done, 0);
            tick();
        end

`ifdef TRANS_DELAY_EN
        // Three idle cycles between accept and the next request
        delay = 8'd3; ready = 1'b1;
        launch(2'd1, 2'd2, 31'h200, 31'd1, 32'd2);
        check("dly_valid0", valid, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            check("dly_gap", valid, 0);
            tick();
        end
        check("dly_valid1", valid, 1);
        check("dly_addr1", addr, 31'h201);
        tick();
        check("dly_valid_end", valid, 0);
        check("dly_cnt", done_cnt, 2);
        tick(); tick();
        check("dly_done", test_done, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
Test-level controller that drives the transmitter block's control interface: trans_valid / trans_addr / trans_type.
- Loads test parameters when started from the CSR block.
- Generates the address stream (fixed, random or running) and the write/read ordering for the selected test mode.
- Counts accepted transactions, aborts on a compare error, and reports completion and result back to the CSR block.

Parameters:
ADDR_W, 31, transaction address width; matches the transmitter trans_addr width.
CNT_W, 32, width of the transaction counter and the status counter.
LFSR_SEED, 32'hACE1_2468, reset/start seed of the random-address LFSR; must be non-zero.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  single-cycle start strobe from the CSR block
test_mode_i  in  2  0=READ_ONLY, 1=WRITE_ONLY, 2=WRITE_AND_CHECK, 3=reserved (treated as READ_ONLY)
addr_mode_i  in  2  0=FIX_ADDR, 1=RND_ADDR, 2=RUN_ADDR, 3=reserved (treated as FIX_ADDR)
base_addr_i  in  ADDR_W  fixed address / running start address
addr_incr_i  in  ADDR_W  running-address increment
trans_count_i  in  CNT_W  number of address units to test
trans_ready_i  in  1  transmitter ready
trans_busy_i  in  1  transmitter has a stored or in-flight transaction
cmp_error_i  in  1  compare block error strobe
trans_valid_o  out  1  transaction request
trans_addr_o  out  ADDR_W  transaction address
trans_type_o  out  1  0=write, 1=read
test_busy_o  out  1  test running
test_done_o  out  1  one-cycle completion strobe
test_result_o  out  1  1=error detected; valid from test_done_o until next start
trans_done_cnt_o  out  CNT_W  accepted-transaction count for the current/last test

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, LFSR = LFSR_SEED.
- Inputs start_i, test_mode_i, addr_mode_i, base_addr_i, addr_incr_i and trans_count_i are sampled only on start_i in IDLE.
- start_i in any other state is ignored.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE + start_i:
  - Latch params; clear trans_done_cnt_o and test_result_o; reload LFSR with LFSR_SEED.
  - If trans_count_i == 0, go to DONE. Otherwise go to ISSUE, with trans_valid_o = 1 on the next cycle (1-cycle latency).
- ISSUE:
  - trans_valid_o is held high. trans_addr_o and trans_type_o are stable while valid && !ready.
  - A transfer is accepted when trans_valid_o && trans_ready_i. Each accept increments trans_done_cnt_o (wraps at 2^CNT_W).
- Ordering per address unit:
  - READ_ONLY: one read.
  - WRITE_ONLY: one write.
  - WRITE_AND_CHECK: write, then read of the same address. The address is held across the pair.
- The address unit counter decrements when the unit's last transfer is accepted. When it reaches 0 on an accept: drop trans_valid_o the same edge and go to DRAIN.
- Address generation, advanced after a unit completes:
  - FIX_ADDR: base_addr_i always.
  - RUN_ADDR: addr += addr_incr_i, modulo 2^ADDR_W.
  - RND_ADDR: 32-bit Galois LFSR (x^32+x^22+x^2+x+1) steps once per unit; trans_addr_o = LFSR[ADDR_W-1:0]. The first address is the seed itself.
- DRAIN: wait for trans_busy_i == 0, then go to DONE.
- DONE: test_done_o = 1 for exactly one cycle; go to IDLE. test_busy_o = 1 in ISSUE and DRAIN only.
- cmp_error_i:
  - In ISSUE: test_result_o <= 1, trans_valid_o <= 0 on the next edge (even mid-handshake), go to DRAIN.
  - In DRAIN: test_result_o <= 1.
  - In IDLE: ignored.
  - If cmp_error_i coincides with an accept, the accept still counts.
- Synchronous reset mid-test: returns to IDLE next edge; no test_done_o is generated.

Optional Feature:
TRANS_DELAY_EN.
- With the macro: extra port delay_i (in, 8 bits), sampled at start. After each accept, trans_valid_o stays low for delay_i cycles before the next request. delay_i = 0 gives back-to-back requests. An error during the gap goes straight to DRAIN.
- Without the macro: no port; requests are back-to-back (valid stays high across accepts).

Decomposition:
- rtl_settings_pkg additions:
  - typedef addr_mode_t {FIX_ADDR, RND_ADDR, RUN_ADDR}.
  - typedef seq_state_t.
  - LFSR polynomial constant.
  - Reuse the existing test_mode_t.
- One natural sub-module: addr_gen, holding the address register and LFSR with load/advance/mode inputs.

Test Plan:
- WRITE_ONLY, RUN_ADDR, base=0x100, incr=4, count=3, ready tied 1 -> writes at 0x100, 0x104, 0x108 on consecutive cycles; after busy low, test_done_o pulse; result 0; trans_done_cnt_o = 3.
- WRITE_AND_CHECK, FIX_ADDR 0x40, count=2 -> type sequence W,R,W,R all at 0x40; trans_done_cnt_o = 4.
- RND_ADDR, count=4, ready toggling 1-of-3 cycles -> addr/type stable while not ready; addresses match the reference LFSR model starting at seed 0xACE12468 (masked to ADDR_W).
- cmp_error_i pulsed after the 2nd accept of count=10 -> valid low next cycle; DRAIN until busy low; test_done_o with test_result_o = 1; trans_done_cnt_o = 2.
- count=0 start -> no valid; test_done_o 2 cycles after start; result 0. Reset asserted mid-ISSUE -> all outputs 0 next edge; no test_done_o.
- TRANS_DELAY_EN, delay_i=3 -> exactly 3 idle cycles between accept and the next valid.
